// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC datapath stages.
//   vn_state_e  : variable-node update FSM states
//   MAX_DEG     : largest supported variable-node degree
//   ACC_GUARD   : guard bits added to message width for accumulation
//   sat_limit() : largest magnitude of a symmetric-saturated WIDTH-bit message
package ldpc_pkg;

    localparam int MAX_DEG   = 8;
    localparam int ACC_GUARD = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } vn_state_e;

    // Symmetric limit: the most negative code is never produced, so a
    // downstream negation cannot overflow.
    function automatic int sat_limit(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

endpackage

// File: rtl/ldpc_sat.sv
// Symmetric saturation of a guarded accumulator value down to message width.
//   din  : WIDTH+4 bit two's-complement value
//   dout : WIDTH bit value clipped to [-(2^(WIDTH-1)-1), +(2^(WIDTH-1)-1)]
module ldpc_sat
    import ldpc_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic [WIDTH+ACC_GUARD-1:0] din,
    output logic [WIDTH-1:0]           dout
);

    localparam int IN_W = WIDTH + ACC_GUARD;
    localparam logic signed [IN_W-1:0] POS_LIM = IN_W'(sat_limit(WIDTH));
    localparam logic signed [IN_W-1:0] NEG_LIM = -POS_LIM;

    logic signed [IN_W-1:0] din_s;

    assign din_s = din;

    always_comb begin
        dout = din_s[WIDTH-1:0];
        if (din_s > POS_LIM) begin
            dout = POS_LIM[WIDTH-1:0];
        end else if (din_s < NEG_LIM) begin
            dout = NEG_LIM[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/vn_update.sv
// LDPC variable-node update. Accumulates the channel LLR and DEG incoming
// check-to-variable messages, then emits DEG extrinsic messages
// sat(total - msg_i) in arrival order, plus a registered hard decision.
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start, ch_llr       : begin a node, channel LLR sampled with start
//   in_valid/in_ready/in_msg            : check-to-variable stream
//   out_valid/out_ready/out_msg/out_last: variable-to-check stream
//   hard_bit            : 1 when the node's total LLR is negative
//   busy                : node in progress
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_ACCUM | accepting DEG input messages into msg_buf and acc
// ST_EMIT  | presenting sat(acc - msg_buf[idx]) until last handshake
module vn_update
    import ldpc_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int DEG   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] ch_llr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_msg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_msg,
    output logic             out_last,
    output logic             hard_bit,
    output logic             busy
);

    localparam int ACC_W = WIDTH + ACC_GUARD;
    localparam int CNT_W = $clog2(DEG);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEG - 1);

    vn_state_e                state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         idx_q, idx_d;
    logic                     hard_bit_q, hard_bit_d;
    logic [WIDTH-1:0]         msg_buf_q [DEG];
    logic [WIDTH-1:0]         msg_buf_d [DEG];

    logic [WIDTH-1:0]         buf_sel;
    logic signed [ACC_W-1:0]  ext_ch, ext_in, ext_buf, diff;
    logic [WIDTH-1:0]         sat_out;

    assign ext_ch  = {{ACC_GUARD{ch_llr[WIDTH-1]}}, ch_llr};
    assign ext_in  = {{ACC_GUARD{in_msg[WIDTH-1]}}, in_msg};
    assign buf_sel = msg_buf_q[idx_q];
    assign ext_buf = {{ACC_GUARD{buf_sel[WIDTH-1]}}, buf_sel};
    // acc holds ch + all DEG messages, so removing one leaves the extrinsic sum.
    assign diff    = acc_q - ext_buf;

    ldpc_sat #(.WIDTH(WIDTH)) u_sat (
        .din  (diff),
        .dout (sat_out)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        hard_bit_d = hard_bit_q;
        msg_buf_d  = msg_buf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = ext_ch;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    msg_buf_d[cnt_q] = in_msg;
                    acc_d            = acc_q + ext_in;
                    if (cnt_q == LAST_IDX) begin
                        // Decision uses the final sum, captured as EMIT is entered.
                        hard_bit_d = acc_d[ACC_W-1];
                        cnt_d      = '0;
                        state_d    = ST_EMIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            hard_bit_q <= 1'b0;
            for (int i = 0; i < DEG; i++) begin
                msg_buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            hard_bit_q <= hard_bit_d;
            msg_buf_q  <= msg_buf_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_EMIT);
    assign out_last  = (state_q == ST_EMIT) && (idx_q == LAST_IDX);
    assign out_msg   = (state_q == ST_EMIT) ? sat_out : '0;
    assign hard_bit  = hard_bit_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vn_update.sv
module tb_vn_update;

    localparam int W   = 20;
    localparam int W8  = 8;
    localparam int DEG = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0]  ch_llr = '0, in_msg = '0;
    logic          in_ready, out_valid, out_last, hard_bit, busy;
    logic [W-1:0]  out_msg;

    logic          s_start = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b1;
    logic [W8-1:0] s_ch_llr = '0, s_in_msg = '0;
    logic          s_in_ready, s_out_valid, s_out_last, s_hard_bit, s_busy;
    logic [W8-1:0] s_out_msg;

    int tests_run = 0;
    int failed    = 0;

    logic [W:0]  sb_q  [$];
    logic [W8:0] sb8_q [$];

    always #5 clk = ~clk;

    vn_update #(.WIDTH(W), .DEG(DEG)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ch_llr(ch_llr),
        .in_valid(in_valid), .in_ready(in_ready), .in_msg(in_msg),
        .out_valid(out_valid), .out_ready(out_ready), .out_msg(out_msg),
        .out_last(out_last), .hard_bit(hard_bit), .busy(busy)
    );

    vn_update #(.WIDTH(W8), .DEG(DEG)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .ch_llr(s_ch_llr),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_msg(s_in_msg),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_msg(s_out_msg),
        .out_last(s_out_last), .hard_bit(s_hard_bit), .busy(s_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int m, input bit last);
        sb_q.push_back({last, W'(m)});
    endtask

    task automatic push_exp8(input int m, input bit last);
        sb8_q.push_back({last, W8'(m)});
    endtask

    // Drive one node on the WIDTH=20 instance with in_valid held high.
    // Returns one cycle after the last message edge (first EMIT cycle).
    task automatic feed_node(input int ch, input int a, input int b, input int c);
        start = 1'b1; ch_llr = W'(ch);
        tick;
        start = 1'b0; in_valid = 1'b1; in_msg = W'(a);
        tick;
        in_msg = W'(b);
        tick;
        in_msg = W'(c);
        tick;
        in_valid = 1'b0;
    endtask

    task automatic feed_node8(input int ch, input int a, input int b, input int c);
        s_start = 1'b1; s_ch_llr = W8'(ch);
        tick;
        s_start = 1'b0; s_in_valid = 1'b1; s_in_msg = W8'(a);
        tick;
        s_in_msg = W8'(b);
        tick;
        s_in_msg = W8'(c);
        tick;
        s_in_valid = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sb_q.size() == 0 && sb8_q.size() == 0 && !busy && !s_busy) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
    endtask

    // Scoreboard: pop and compare on every output handshake of either instance.
    task automatic sb_monitor;
        logic [W:0]  e20;
        logic [W8:0] e8;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                tests_run++;
                if (sb_q.size() == 0) begin
                    failed++;
                    $display("FAIL sb_out20 unexpected output msg=%0d last=%0b, nothing expected",
                             $signed(out_msg), out_last);
                end else begin
                    e20 = sb_q.pop_front();
                    if ({out_last, out_msg} !== e20) begin
                        failed++;
                        $display("FAIL sb_out20 got msg=%0d last=%0b expected msg=%0d last=%0b",
                                 $signed(out_msg), out_last, $signed(e20[W-1:0]), e20[W]);
                    end
                end
            end
            if (s_out_valid && s_out_ready) begin
                tests_run++;
                if (sb8_q.size() == 0) begin
                    failed++;
                    $display("FAIL sb_out8 unexpected output msg=%0d last=%0b, nothing expected",
                             $signed(s_out_msg), s_out_last);
                end else begin
                    e8 = sb8_q.pop_front();
                    if ({s_out_last, s_out_msg} !== e8) begin
                        failed++;
                        $display("FAIL sb_out8 got msg=%0d last=%0b expected msg=%0d last=%0b",
                                 $signed(s_out_msg), s_out_last, $signed(e8[W8-1:0]), e8[W8]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset;
        #3;
        tests_run++;
        if ({in_ready, out_valid, out_last, hard_bit, busy} !== 5'b0) begin
            failed++;
            $display("FAIL reset_flags got %b expected 00000", {in_ready, out_valid, out_last, hard_bit, busy});
        end
        tests_run++;
        if (out_msg !== '0) begin
            failed++;
            $display("FAIL reset_out_msg got %0d expected 0", $signed(out_msg));
        end
        tick;
        rst_n = 1'b1;
        tick;
        tests_run++;
        if (busy !== 1'b0 || s_busy !== 1'b0) begin
            failed++;
            $display("FAIL reset_release_busy got %b/%b expected 0/0", busy, s_busy);
        end
    endtask

    task automatic test_basic;
        bit ok;
        out_ready = 1'b1;
        push_exp(14, 1'b0); push_exp(22, 1'b0); push_exp(12, 1'b1);
        start = 1'b1; ch_llr = W'(10);
        tick;
        start = 1'b0; in_valid = 1'b1; in_msg = W'(5);
        tick;
        in_msg = W'(-3);
        tick;
        in_msg = W'(7);
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failed++;
            $display("FAIL basic_pre_emit got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        tick;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_last !== 1'b0) begin
            failed++;
            $display("FAIL basic_latency got out_valid=%b in_ready=%b out_last=%b expected 1/0/0",
                     out_valid, in_ready, out_last);
        end
        tests_run++;
        if (hard_bit !== 1'b0) begin
            failed++;
            $display("FAIL basic_hard_bit got %b expected 0", hard_bit);
        end
        wait_drain(ok);
        tests_run++;
        if (!ok) begin
            failed++;
            $display("FAIL basic_drain got %0d pending expected 0", sb_q.size());
        end
        // Negative node: total -59 -> -54, -62, -52
        push_exp(-54, 1'b0); push_exp(-62, 1'b0); push_exp(-52, 1'b1);
        feed_node(-50, -5, 3, -7);
        tests_run++;
        if (hard_bit !== 1'b1) begin
            failed++;
            $display("FAIL basic_neg_hard_bit got %b expected 1", hard_bit);
        end
        wait_drain(ok);
        tests_run++;
        if (!ok) begin
            failed++;
            $display("FAIL basic_neg_drain got %0d pending expected 0", sb_q.size());
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        start = 1'b1; ch_llr = W'(10);
        tick;
        start = 1'b0; in_valid = 1'b1; in_msg = W'(5);
        tick;
        in_msg = W'(-3);
        tick;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({in_ready, out_valid, out_last, hard_bit, busy} !== 5'b0 || out_msg !== '0) begin
            failed++;
            $display("FAIL reset_mid_async got flags=%b msg=%0d expected 00000/0",
                     {in_ready, out_valid, out_last, hard_bit, busy}, $signed(out_msg));
        end
        tick;
        rst_n = 1'b1;
        push_exp(2, 1'b0); push_exp(2, 1'b0); push_exp(2, 1'b1);
        feed_node(0, 1, 1, 1);
        tests_run++;
        if (out_valid !== 1'b1) begin
            failed++;
            $display("FAIL reset_mid_first_start got out_valid=%b expected 1", out_valid);
        end
        wait_drain(ok);
        tests_run++;
        if (!ok) begin
            failed++;
            $display("FAIL reset_mid_drain got %0d pending expected 0", sb_q.size());
        end
    endtask

    task automatic test_saturation;
        bit ok;
        push_exp8(127, 1'b0); push_exp8(127, 1'b0); push_exp8(127, 1'b1);
        feed_node8(100, 100, 100, -5);
        tests_run++;
        if (s_hard_bit !== 1'b0) begin
            failed++;
            $display("FAIL sat_pos_hard_bit got %b expected 0", s_hard_bit);
        end
        wait_drain(ok);
        push_exp8(-127, 1'b0); push_exp8(-127, 1'b0); push_exp8(-127, 1'b1);
        feed_node8(-100, -100, -100, 5);
        tests_run++;
        if (s_hard_bit !== 1'b1) begin
            failed++;
            $display("FAIL sat_neg_hard_bit got %b expected 1", s_hard_bit);
        end
        wait_drain(ok);
        tests_run++;
        if (!ok) begin
            failed++;
            $display("FAIL sat_drain got %0d pending expected 0", sb8_q.size());
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        out_ready = 1'b1;
        push_exp(14, 1'b0); push_exp(22, 1'b0); push_exp(12, 1'b1);
        feed_node(10, 5, -3, 7);
        tick;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_msg !== W'(22) || out_last !== 1'b0) begin
                failed++;
                $display("FAIL bp_hold_mid got valid=%b msg=%0d last=%b expected 1/22/0",
                         out_valid, $signed(out_msg), out_last);
            end
            tick;
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_msg !== W'(12) || out_last !== 1'b1) begin
                failed++;
                $display("FAIL bp_hold_last got valid=%b msg=%0d last=%b expected 1/12/1",
                         out_valid, $signed(out_msg), out_last);
            end
            tick;
        end
        out_ready = 1'b1;
        wait_drain(ok);
        tests_run++;
        if (!ok) begin
            failed++;
            $display("FAIL bp_drain got %0d pending expected 0", sb_q.size());
        end
    endtask

    task automatic test_protocol;
        bit ok;
        out_ready = 1'b1;
        push_exp(14, 1'b0); push_exp(22, 1'b0); push_exp(12, 1'b1);
        feed_node(10, 5, -3, 7);
        start = 1'b1; ch_llr = W'(55); in_valid = 1'b1; in_msg = W'(99);
        tick;
        start = 1'b0; in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failed++;
            $display("FAIL proto_emit_hold got out_valid=%b in_ready=%b expected 1/0", out_valid, in_ready);
        end
        tick;
        start = 1'b1; ch_llr = W'(77);
        tick;
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL proto_start_on_last got busy=%b expected 0", busy);
        end
        wait_drain(ok);
        tests_run++;
        if (!ok) begin
            failed++;
            $display("FAIL proto_drain got %0d pending expected 0", sb_q.size());
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        out_ready = 1'b1;
        push_exp(14, 1'b0); push_exp(22, 1'b0); push_exp(12, 1'b1);
        push_exp(8, 1'b0);  push_exp(7, 1'b0);  push_exp(6, 1'b1);
        feed_node(10, 5, -3, 7);
        tick;
        tick;
        tests_run++;
        if (out_last !== 1'b1) begin
            failed++;
            $display("FAIL b2b_last got out_last=%b expected 1", out_last);
        end
        tick;
        feed_node(1, 2, 3, 4);
        tests_run++;
        if (out_valid !== 1'b1) begin
            failed++;
            $display("FAIL b2b_second_start got out_valid=%b expected 1", out_valid);
        end
        wait_drain(ok);
        tests_run++;
        if (!ok) begin
            failed++;
            $display("FAIL b2b_drain got %0d pending expected 0", sb_q.size());
        end
    endtask

    initial begin
        fork
            sb_monitor();
        join_none
        test_reset();
        test_basic();
        test_reset_mid();
        test_saturation();
        test_backpressure();
        test_protocol();
        test_back_to_back();
        tick;
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vn_update.md
VN_UPDATE -- requirements
Module: vn_update

Interface
REQ-001 SHALL have parameter WIDTH, default 20, meaning two's-complement LLR/message width.
REQ-002 SHALL have parameter DEG, default 3, legal range 2..8, meaning variable-node degree (check-to-variable messages per node).
REQ-003 SHALL use one clock; reset is asynchronous and active-low: clk input 1 rising-edge clock; rst_n input 1 async active-low reset.
REQ-004 start input 1: one-cycle pulse that begins a node; ch_llr is sampled in the same cycle.
REQ-005 ch_llr input WIDTH: channel LLR for the node.
REQ-006 in_valid input 1, in_ready output 1, in_msg input WIDTH: check-to-variable message stream.
REQ-007 out_valid output 1, out_ready input 1, out_msg output WIDTH, out_last output 1: variable-to-check message stream.
REQ-008 hard_bit output 1: hard decision, 1 when total LLR < 0.
REQ-009 busy output 1: high in any state other than IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, ACCUM, EMIT.
REQ-011 In IDLE, start SHALL load acc = sign-extended ch_llr, clear cnt and idx, and move to ACCUM.
REQ-012 acc SHALL be WIDTH+4 bits signed; no internal overflow is possible for DEG<=8.
REQ-013 In ACCUM, in_ready SHALL be 1; each in_valid&&in_ready cycle SHALL store in_msg in buf[cnt], add it to acc, and increment cnt.
REQ-014 After the DEG-th accepted message, the FSM SHALL enter EMIT on the next edge, with in_ready 0 from that cycle.
REQ-015 On entry to EMIT, hard_bit SHALL register the sign of final acc and hold until the next EMIT entry.
REQ-016 In EMIT, out_valid SHALL be 1 and out_msg SHALL equal sat(acc - buf[idx]), emitted in arrival order.
REQ-017 sat() SHALL clip to the symmetric range [-(2^(WIDTH-1)-1), +(2^(WIDTH-1)-1)], so downstream negation never overflows.
REQ-018 out_msg and out_last SHALL stay stable while out_valid && !out_ready.
REQ-019 Each out_valid&&out_ready SHALL increment idx; out_last SHALL be 1 when idx == DEG-1.
REQ-020 Handshake on out_last SHALL return the FSM to IDLE; start in that same cycle SHALL be ignored.
REQ-021 start while busy SHALL be ignored, with no state change.
REQ-022 in_valid outside ACCUM SHALL be ignored, since in_ready is 0 there.
REQ-023 Minimum latency start->first out_valid SHALL be DEG+1 cycles with in_valid held high.
REQ-024 Back-to-back nodes: start SHALL be accepted the cycle after the out_last handshake.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, with in_ready=0, out_valid=0, out_msg=0, out_last=0, hard_bit=0, busy=0; acc, cnt, idx and buf SHALL be cleared.
REQ-026 Reset mid-ACCUM or mid-EMIT SHALL discard the node; no partial output SHALL appear after release.
REQ-027 After release, the first start SHALL be honoured on the first rising edge with rst_n high.

Structure
REQ-028 State enum, MAX_DEG=8, and the saturation-limit function of WIDTH SHALL live in shared package ldpc_pkg.
REQ-029 Saturation SHALL be one sub-module, ldpc_sat (input WIDTH+4, output WIDTH), reusable by other LDPC stages.
REQ-030 buf SHALL be a DEG-entry register array, not inferred RAM.

Verification
REQ-031 Basic (WIDTH=20, DEG=3): ch=10, msgs 5,-3,7 -> out 14,22,12; out_last on third; hard_bit=0.
REQ-032 Saturation (WIDTH=8, DEG=3): ch=100, msgs 100,100,-5 -> out 127,127,127; ch=-100, msgs -100,-100,5 -> out -127,-127,-127, hard_bit=1.
REQ-033 Backpressure: out_ready low 3 cycles during EMIT -> out_msg/out_last unchanged, no message lost or duplicated.
REQ-034 Protocol: start and in_valid pulsed during EMIT -> ignored; outputs match REQ-031.
REQ-035 Reset: rst_n low after 2 of 3 messages, then a fresh node (ch=0, msgs 1,1,1) -> no stale output; out 2,2,2.
REQ-036 Throughput: two nodes back-to-back with in_valid/out_ready always high -> second start accepted cycle after first out_last handshake.
